// File: rtl/cpu_pipe_pkg.sv
// Shared constants for the 5-stage ARM pipeline: NZCV bit positions,
// zero-register specifier and default datapath widths.
package cpu_pipe_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_REG_W  = 5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/D_FF_enable.sv
// Single-bit D flip-flop with synchronous active-high reset and load enable.
module D_FF_enable (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else if (enable) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/flag_register.sv
// Architectural NZCV store with commit enable, plus the same-cycle bypass
// that lets branch logic see flags produced by the instruction now in EX.
module flag_register
  import cpu_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       commit_en,
  input  logic       bypass_en,
  input  logic [3:0] flags_alu,
  output logic [3:0] flags_q,
  output logic [3:0] flags_current
);

  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;

  always_comb begin
    nzcv_d = nzcv_q;
    if (commit_en) begin
      nzcv_d = flags_alu;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q <= 4'b0000;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign flags_q       = nzcv_q;
  assign flags_current = bypass_en ? flags_alu : nzcv_q;

endmodule

// File: rtl/execute_register.sv
// EX/MEM pipeline register with stall/flush handling and the NZCV flag
// register feeding both the memory stage and conditional-branch resolution.
module execute_register
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_Execute,
  input  logic [DATA_W-1:0] ALUResult_Execute,
  input  logic [DATA_W-1:0] WrData_Execute,
  input  logic [REG_W-1:0]  Rd_Execute,
  input  logic              MemWrite_Execute,
  input  logic              MemToReg_Execute,
  input  logic              RegWrite_Execute,
  input  logic              setFlag_Execute,
  input  logic [3:0]        flags_ALU,
  output logic              valid_ExecuteRegister,
  output logic [DATA_W-1:0] ALUResult_ExecuteRegister,
  output logic [DATA_W-1:0] WrData_ExecuteRegister,
  output logic [REG_W-1:0]  Rd_ExecuteRegister,
  output logic              MemWrite_ExecuteRegister,
  output logic              MemToReg_ExecuteRegister,
  output logic              RegWrite_ExecuteRegister,
  output logic [3:0]        flags_Register,
  output logic [3:0]        flags_Current
);

  localparam int PIPE_W = 2 * DATA_W + REG_W + 4;

  logic              bubble;
  logic              reg_write_d;
  logic              flag_live;
  logic [PIPE_W-1:0] pipe_load;
  logic [PIPE_W-1:0] pipe_d;
  logic [PIPE_W-1:0] pipe_q;

  // Writes to XZR are discarded at capture so MEM/WB never see them.
  assign reg_write_d = RegWrite_Execute & (Rd_Execute != REG_W'(XZR));
  assign bubble      = flush | ~valid_Execute;
  assign flag_live   = valid_Execute & setFlag_Execute & ~flush;

  assign pipe_load = {valid_Execute, ALUResult_Execute, WrData_Execute, Rd_Execute,
                      MemWrite_Execute, MemToReg_Execute, reg_write_d};
  assign pipe_d    = bubble ? '0 : pipe_load;

  for (genvar i = 0; i < PIPE_W; i++) begin : g_pipe
    D_FF_enable u_bit (
      .clk    (clk),
      .reset  (reset),
      .enable (~stall),
      .d      (pipe_d[i]),
      .q      (pipe_q[i])
    );
  end

  assign {valid_ExecuteRegister, ALUResult_ExecuteRegister, WrData_ExecuteRegister,
          Rd_ExecuteRegister, MemWrite_ExecuteRegister, MemToReg_ExecuteRegister,
          RegWrite_ExecuteRegister} = pipe_q;

  flag_register u_flags (
    .clk           (clk),
    .reset         (reset),
    .commit_en     (flag_live & ~stall),
    .bypass_en     (flag_live),
    .flags_alu     (flags_ALU),
    .flags_q       (flags_Register),
    .flags_current (flags_Current)
  );

endmodule
